// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- fetch-control bus between decode/branch logic and the
// PC sequencer.
//   master : decode/branch side. Drives branch, isBranch, jump, target and
//            stall. Observes pc, instrValid, flush and misaligned.
//   slave  : the sequencer. Observes the decode/branch inputs and drives
//            the fetch-side outputs.
interface pc_sequencer_if #(
  parameter int N = 32
);
  logic         branch;      // branch-taken decision
  logic         isBranch;    // current instruction is a conditional branch
  logic         jump;        // current instruction is JAL/JALR
  logic [N-1:0] target;      // redirect target address
  logic         stall;       // downstream hazard hold request
  logic [N-1:0] pc;          // current fetch address
  logic         instrValid;  // instruction at pc is valid this cycle
  logic         flush;       // one-cycle pulse: drop younger instructions
  logic         misaligned;  // sticky misaligned-target flag

  modport master (
    output branch, isBranch, jump, target, stall,
    input  pc, instrValid, flush, misaligned
  );

  modport slave (
    input  branch, isBranch, jump, target, stall,
    output pc, instrValid, flush, misaligned
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter sequencer with redirect bubbles.
//   clk   : single clock. All state updates on the rising edge.
//   rst_n : synchronous, active-low reset.
//   bus   : pc_sequencer_if.slave.
//           Inputs are branch, isBranch, jump, target and stall.
//           Outputs are pc, instrValid, flush and misaligned.
// States are BOOT, RUN and FLUSH, plus TRAP when the optional feature is enabled.
// A redirect is (isBranch & branch) | jump. It is sampled only in RUN and it
// wins over stall. A redirect loads the word-aligned target, pulses flush
// once and inserts FLUSH_CYCLES invalid cycles.
// Optional feature: define MISALIGN_TRAP_EN to compile in misaligned-target
// detection. With the macro defined, a redirect to a target whose low two
// bits are not zero does not load pc. Instead it sets the sticky misaligned
// flag, pulses flush and parks the sequencer in TRAP until reset. Without the
// macro, target[1:0] is dropped and misaligned is tied low.
module pc_sequencer #(
  parameter int           N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = N'(32'h0000_0000),
  parameter int           FLUSH_CYCLES = 2
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2, TRAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
`endif

  // The bubble counter is 3 bits wide because the legal FLUSH_CYCLES range is 1..7.
  localparam logic [2:0]   FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [N-1:0] PC_STEP    = N'(32'd4);

  state_t       state_r;
  logic [N-1:0] pc_r;
  logic [2:0]   cnt_r;
  logic         flush_r;
  logic         valid_r;
  logic         redirect_s;
  logic [N-1:0] aligned_target_s;

  assign redirect_s       = (bus.isBranch & bus.branch) | bus.jump;
  assign aligned_target_s = {bus.target[N-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  logic misaligned_r;
  logic target_misaligned_s;

  assign target_misaligned_s = |bus.target[1:0];
  assign bus.misaligned      = misaligned_r;
`else
  assign bus.misaligned = 1'b0;
`endif

  assign bus.pc         = pc_r;
  assign bus.instrValid = valid_r;
  assign bus.flush      = flush_r;

  // Sequencer FSM. The valid and flush registers are updated together with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= BOOT;
      pc_r         <= RESET_VECTOR;
      cnt_r        <= 3'd0;
      flush_r      <= 1'b0;
      valid_r      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned_r <= 1'b0;
`endif
    end else begin
      // By default flush is low. It is raised only on the edge that accepts a redirect.
      flush_r <= 1'b0;
      case (state_r)
        BOOT: begin
          state_r <= RUN;
          pc_r    <= RESET_VECTOR;
          valid_r <= 1'b1;
        end
        RUN: begin
          if (redirect_s) begin
`ifdef MISALIGN_TRAP_EN
            if (target_misaligned_s) begin
              // A bad target is never fetched. pc stays at the redirecting instruction.
              state_r      <= TRAP;
              misaligned_r <= 1'b1;
              flush_r      <= 1'b1;
              valid_r      <= 1'b0;
            end else begin
              state_r <= FLUSH;
              pc_r    <= aligned_target_s;
              cnt_r   <= FLUSH_LOAD;
              flush_r <= 1'b1;
              valid_r <= 1'b0;
            end
`else
            state_r <= FLUSH;
            pc_r    <= aligned_target_s;
            cnt_r   <= FLUSH_LOAD;
            flush_r <= 1'b1;
            valid_r <= 1'b0;
`endif
          end else if (!bus.stall) begin
            pc_r    <= pc_r + PC_STEP;
            valid_r <= 1'b1;
          end else begin
            pc_r    <= pc_r;
            valid_r <= 1'b1;
          end
        end
        FLUSH: begin
          // Bubbles drain even while stall is high. A count of zero is treated like one so the FSM cannot wedge.
          if (cnt_r <= 3'd1) begin
            state_r <= RUN;
            cnt_r   <= 3'd0;
            valid_r <= 1'b1;
          end else begin
            cnt_r   <= cnt_r - 3'd1;
            valid_r <= 1'b0;
          end
        end
`ifdef MISALIGN_TRAP_EN
        TRAP: begin
          valid_r <= 1'b0;
        end
`endif
        default: begin
          state_r <= BOOT;
          pc_r    <= RESET_VECTOR;
          cnt_r   <= 3'd0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- directed bench for pc_sequencer.
// Applies a cycle-by-cycle vector table (inputs plus expected outputs after
// the edge), then hand-written sequences for a reset during FLUSH and for a
// misaligned target.
module tb_pc_sequencer;
  localparam int N = 32;

  typedef struct {
    logic        rst_n;
    logic        isb;
    logic        br;
    logic        jmp;
    logic [31:0] tgt;
    logic        st;
    logic [31:0] epc;
    logic        ev;
    logic        ef;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_sequencer_if #(.N(N)) bus ();

  pc_sequencer #(
    .N(N),
    .RESET_VECTOR(32'h0000_0000),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic r, input logic isb, input logic br,
                               input logic jmp, input logic [31:0] tgt, input logic st,
                               input logic [31:0] epc, input logic ev, input logic ef);
    vec_t v;
    v.rst_n = r; v.isb = isb; v.br = br; v.jmp = jmp; v.tgt = tgt; v.st = st;
    v.epc = epc; v.ev = ev; v.ef = ef;
    return v;
  endfunction

  task automatic step(input logic r, input logic isb, input logic br, input logic jmp,
                      input logic [31:0] tgt, input logic st);
    rst_n        = r;
    bus.isBranch = isb;
    bus.branch   = br;
    bus.jump     = jmp;
    bus.target   = tgt;
    bus.stall    = st;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] epc, input logic ev,
                       input logic ef, input logic em);
    n_checks += 4;
    if (bus.pc !== epc) begin
      n_fail++;
      $display("FAIL %s pc: got %h expected %h", name, bus.pc, epc);
    end
    if (bus.instrValid !== ev) begin
      n_fail++;
      $display("FAIL %s instrValid: got %b expected %b", name, bus.instrValid, ev);
    end
    if (bus.flush !== ef) begin
      n_fail++;
      $display("FAIL %s flush: got %b expected %b", name, bus.flush, ef);
    end
    if (bus.misaligned !== em) begin
      n_fail++;
      $display("FAIL %s misaligned: got %b expected %b", name, bus.misaligned, em);
    end
  endtask

  initial begin
    vec_t vecs[$];

    rst_n        = 1'b0;
    bus.isBranch = 1'b0;
    bus.branch   = 1'b0;
    bus.jump     = 1'b0;
    bus.target   = 32'h0;
    bus.stall    = 1'b0;

    //                rst  isb   br    jmp   target        stall  exp pc        v     f
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0)); // reset/BOOT
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0)); // first RUN
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0004, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0008, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_000C, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0010, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 1'b0, 32'h0000_0040, 1'b0, 1'b1)); // taken branch
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0040, 1'b0, 1'b0)); // bubble 2
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0040, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0044, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0044, 1'b1, 1'b0)); // stall hold
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0044, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0020, 1'b0, 1'b1)); // jump
    vecs.push_back(mkv(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0020, 1'b0, 1'b0)); // ignored in FLUSH
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0020, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0, 1'b1)); // redirect beats stall
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 1'b0)); // stall in FLUSH
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0104, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 1'b0, 32'h0000_0108, 1'b1, 1'b0)); // not taken
    vecs.push_back(mkv(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 1'b0, 32'h0000_010C, 1'b1, 1'b0)); // branch w/o isBranch
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_010C, 1'b0, 32'h0000_010C, 1'b0, 1'b1)); // redirect to self
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_010C, 1'b0, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_010C, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0110, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b1)); // to top of space
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0)); // wrap
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0004, 1'b1, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].isb, vecs[i].br, vecs[i].jmp, vecs[i].tgt, vecs[i].st);
      check($sformatf("vec%0d", i), vecs[i].epc, vecs[i].ev, vecs[i].ef, 1'b0);
    end

    // Reset while in FLUSH: the next cycle is BOOT with no flush.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0);
    check("rstflush_redirect", 32'h0000_0080, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    check("rstflush_boot", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    check("rstflush_run", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    check("rstflush_inc", 32'h0000_0004, 1'b1, 1'b0, 1'b0);

    // Misaligned jump target 0x102 issued from pc 0x4.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b0);
`ifdef MISALIGN_TRAP_EN
    check("mis_trap", 32'h0000_0004, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    check("mis_hold", 32'h0000_0004, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    check("mis_ignore", 32'h0000_0004, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    check("mis_reset", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    check("mis_run", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
`else
    check("mis_zeroed", 32'h0000_0100, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    check("mis_bubble", 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    check("mis_run", 32'h0000_0100, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    check("mis_inc", 32'h0000_0104, 1'b1, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
